// File: rtl/fetch_pc_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundles every non-clock signal of the fetch/PC stage.
//   master : the fetch unit (drives fetch_pc, bp_pc and the registered out_* group)
//   slave  : the surroundings (instruction memory, predictor, downstream queue,
//            redirect logic)
// Signals:
//   fetch_pc    PC sent to instruction memory
//   imem_inst   LANES instructions at fetch_pc+i, lane i at [i*INST_WIDTH +: INST_WIDTH]
//   free        downstream slots available this cycle
//   stall       hold the stage
//   flush       mispredict redirect, target in flush_addr
//   bp_take     predictor says the first branch of the group is taken
//   bp_target   predicted target
//   bp_pc       PC of the first branch lane (fetch_pc when there is none)
//   out_valid   registered per-lane push
//   out_pc      registered lane PCs
//   out_id      registered lane IDs
//   out_inst    registered lane instructions
//   out_taken   lane is the predicted-taken branch
//   out_target  predicted target of the taken lane
// ----------------------------------------------------------------------------
interface fetch_pc_unit_if #(
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int ID_WIDTH   = 16
);
    localparam int FREE_WIDTH = $clog2(LANES + 1);

    logic [ADDR_WIDTH-1:0]       fetch_pc;
    logic [LANES*INST_WIDTH-1:0] imem_inst;
    logic [FREE_WIDTH-1:0]       free;
    logic                        stall;
    logic                        flush;
    logic [ADDR_WIDTH-1:0]       flush_addr;
    logic                        bp_take;
    logic [ADDR_WIDTH-1:0]       bp_target;
    logic [ADDR_WIDTH-1:0]       bp_pc;
    logic [LANES-1:0]            out_valid;
    logic [LANES*ADDR_WIDTH-1:0] out_pc;
    logic [LANES*ID_WIDTH-1:0]   out_id;
    logic [LANES*INST_WIDTH-1:0] out_inst;
    logic [LANES-1:0]            out_taken;
    logic [ADDR_WIDTH-1:0]       out_target;

    modport master (
        output fetch_pc, bp_pc, out_valid, out_pc, out_id, out_inst, out_taken, out_target,
        input  imem_inst, free, stall, flush, flush_addr, bp_take, bp_target
    );

    modport slave (
        input  fetch_pc, bp_pc, out_valid, out_pc, out_id, out_inst, out_taken, out_target,
        output imem_inst, free, stall, flush, flush_addr, bp_take, bp_target
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
// N-wide program counter and fetch stage. Predecodes LANES instructions for
// jumps, branches and NOPs, cuts the group at the first redirect, limits it to
// the downstream free slots and registers the surviving lanes (PC, ID,
// instruction, prediction info) into the fetch/decode pipeline register.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    fetch_pc_unit_if.master (memory, predictor, redirect and out_* group)
// ----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int              LANES      = 4,
    parameter int              ADDR_WIDTH = 16,
    parameter int              INST_WIDTH = 32,
    parameter int              ID_WIDTH   = 16,
    parameter int              OPC_MSB    = 31,
    parameter int              OPC_LSB    = 26,
    parameter int              IMM_MSB    = 15,
    parameter int              IMM_LSB    = 0,
    parameter logic [5:0]      OP_JMP     = 6'b110000,
    parameter logic [INST_WIDTH-1:0] NOP_INST = '0,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.master bus
);
    localparam int FREE_WIDTH = $clog2(LANES + 1);
    localparam int OPC_WIDTH  = OPC_MSB - OPC_LSB + 1;
    localparam int IMM_WIDTH  = IMM_MSB - IMM_LSB + 1;

    // architectural state
    logic [ADDR_WIDTH-1:0]       pc_q;
    logic [ID_WIDTH-1:0]         id_q;

    // fetch/decode pipeline register
    logic [LANES-1:0]            out_valid_q;
    logic [LANES*ADDR_WIDTH-1:0] out_pc_q;
    logic [LANES*ID_WIDTH-1:0]   out_id_q;
    logic [LANES*INST_WIDTH-1:0] out_inst_q;
    logic [LANES-1:0]            out_taken_q;
    logic [ADDR_WIDTH-1:0]       out_target_q;

    // per-lane predecode
    logic [INST_WIDTH-1:0]       lane_inst       [LANES];
    logic [OPC_WIDTH-1:0]        lane_opc        [LANES];
    logic [IMM_WIDTH-1:0]        lane_imm        [LANES];
    logic [ADDR_WIDTH-1:0]       lane_pc         [LANES];
    logic [ADDR_WIDTH-1:0]       lane_jmp_target [LANES];
    logic [LANES-1:0]            lane_is_jmp;
    logic [LANES-1:0]            lane_is_br;
    logic [LANES-1:0]            lane_is_nop;

    // group formation
    logic [FREE_WIDTH-1:0]       n_eligible;
    logic [LANES-1:0]            consumed;
    logic [LANES-1:0]            taken_lane;
    logic [LANES-1:0]            push;
    logic [ADDR_WIDTH-1:0]       next_pc;
    logic [ADDR_WIDTH-1:0]       bp_lookup_pc;
    logic [ID_WIDTH-1:0]         next_id;
    logic [LANES*ADDR_WIDTH-1:0] grp_pc;
    logic [LANES*ID_WIDTH-1:0]   grp_id;
    logic [LANES*INST_WIDTH-1:0] grp_inst;
    logic                        advance;

    // A group only moves when nothing holds the stage and downstream can take
    // at least one lane; free above LANES is clipped to the fetch width.
    assign advance    = !bus.stall && (bus.free != '0);
    assign n_eligible = (bus.free > FREE_WIDTH'(LANES)) ? FREE_WIDTH'(LANES) : bus.free;

    // Slice the fetched word into lanes and classify each one. A branch is any
    // opcode with both top bits set except the jump opcode itself.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_inst[i]       = bus.imem_inst[i*INST_WIDTH +: INST_WIDTH];
            lane_opc[i]        = lane_inst[i][OPC_MSB:OPC_LSB];
            lane_imm[i]        = lane_inst[i][IMM_MSB:IMM_LSB];
            lane_pc[i]         = pc_q + ADDR_WIDTH'(i);
            lane_jmp_target[i] = ADDR_WIDTH'(lane_imm[i]);
            lane_is_jmp[i]     = (lane_opc[i] == OP_JMP);
            lane_is_br[i]      = (lane_opc[i][OPC_WIDTH-1 -: 2] == 2'b11) && !lane_is_jmp[i];
            lane_is_nop[i]     = (lane_inst[i] == NOP_INST);
        end
    end

    // Walk the eligible lanes in order. The group stays open until a jump or
    // the first branch when the predictor says taken; only that first branch
    // is offered to the predictor, later ones fall through as not-taken.
    always_comb begin
        logic group_open;
        logic branch_seen;
        group_open   = 1'b1;
        branch_seen  = 1'b0;
        consumed     = '0;
        taken_lane   = '0;
        next_pc      = pc_q + ADDR_WIDTH'(n_eligible);
        bp_lookup_pc = pc_q;
        for (int i = 0; i < LANES; i++) begin
            if (group_open && (FREE_WIDTH'(i) < n_eligible)) begin
                consumed[i] = 1'b1;
                if (lane_is_jmp[i]) begin
                    next_pc    = lane_jmp_target[i];
                    group_open = 1'b0;
                end else if (lane_is_br[i] && !branch_seen) begin
                    branch_seen  = 1'b1;
                    bp_lookup_pc = lane_pc[i];
                    if (bus.bp_take) begin
                        taken_lane[i] = 1'b1;
                        next_pc       = bus.bp_target;
                        group_open    = 1'b0;
                    end
                end
            end
        end
    end

    // Hand out IDs to pushing lanes only, packed consecutively from the
    // counter; dropped lanes and NOPs leave zeros in their slots.
    always_comb begin
        logic [ID_WIDTH-1:0] running;
        running  = id_q;
        push     = '0;
        grp_pc   = '0;
        grp_id   = '0;
        grp_inst = '0;
        for (int i = 0; i < LANES; i++) begin
            push[i] = consumed[i] && !lane_is_nop[i];
            if (push[i]) begin
                grp_pc[i*ADDR_WIDTH +: ADDR_WIDTH]   = lane_pc[i];
                grp_id[i*ID_WIDTH +: ID_WIDTH]       = running;
                grp_inst[i*INST_WIDTH +: INST_WIDTH] = lane_inst[i];
                running                              = running + ID_WIDTH'(1);
            end
        end
        next_id = running;
    end

    // PC, ID counter and pipeline register. Flush outranks a stall and only
    // kills the valid/taken bits so the discarded group never reaches decode;
    // a hold leaves everything untouched so nothing is pushed twice or lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            id_q         <= ID_WIDTH'(1);
            out_valid_q  <= '0;
            out_pc_q     <= '0;
            out_id_q     <= '0;
            out_inst_q   <= '0;
            out_taken_q  <= '0;
            out_target_q <= '0;
        end else if (bus.flush) begin
            pc_q         <= bus.flush_addr;
            out_valid_q  <= '0;
            out_taken_q  <= '0;
        end else if (advance) begin
            pc_q         <= next_pc;
            id_q         <= next_id;
            out_valid_q  <= push;
            out_pc_q     <= grp_pc;
            out_id_q     <= grp_id;
            out_inst_q   <= grp_inst;
            out_taken_q  <= taken_lane;
            out_target_q <= (taken_lane != '0) ? bus.bp_target : '0;
        end
    end

    assign bus.fetch_pc   = pc_q;
    assign bus.bp_pc      = bp_lookup_pc;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_inst   = out_inst_q;
    assign bus.out_taken  = out_taken_q;
    assign bus.out_target = out_target_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Drives fetch_pc_unit with directed groups followed by random traffic. Each
// issued cycle pushes the response predicted by a lane-by-lane model of the
// fetch rules into a queue; a monitor pops one entry after every clock edge
// and compares it with the registered outputs.
// ----------------------------------------------------------------------------
module tb_fetch_pc_unit;
    localparam int LANES = 4;
    localparam int AW    = 16;
    localparam int IW    = 32;
    localparam int IDW   = 16;
    localparam int FW    = $clog2(LANES + 1);

    typedef struct {
        logic [AW-1:0]       pc;
        logic [LANES-1:0]    valid;
        logic [LANES-1:0]    taken;
        logic [AW-1:0]       target;
        logic [LANES*AW-1:0] lane_pc;
        logic [LANES*IDW-1:0] lane_id;
        logic [LANES*IW-1:0] lane_inst;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q [$];

    // reference state
    logic [AW-1:0]        m_pc;
    logic [IDW-1:0]       m_id;
    logic [LANES-1:0]     m_valid;
    logic [LANES-1:0]     m_taken;
    logic [AW-1:0]        m_target;
    logic [LANES*AW-1:0]  m_lane_pc;
    logic [LANES*IDW-1:0] m_lane_id;
    logic [LANES*IW-1:0]  m_lane_inst;

    fetch_pc_unit_if #(.LANES(LANES), .ADDR_WIDTH(AW), .INST_WIDTH(IW), .ID_WIDTH(IDW)) bus ();

    fetch_pc_unit #(.LANES(LANES), .ADDR_WIDTH(AW), .INST_WIDTH(IW), .ID_WIDTH(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [IW-1:0] aluInst();
        logic [5:0] opc;
        opc = 6'($urandom_range(1, 47));
        return {opc, 10'($urandom), 16'($urandom)};
    endfunction

    function automatic logic [IW-1:0] brInst();
        logic [5:0] opc;
        opc = 6'($urandom_range(49, 63));
        return {opc, 10'($urandom), 16'($urandom)};
    endfunction

    function automatic logic [IW-1:0] jmpInst(input logic [15:0] imm);
        return {6'b110000, 10'($urandom), imm};
    endfunction

    function automatic logic [IW-1:0] randInst();
        int r;
        r = $urandom_range(0, 99);
        if (r < 12)      return '0;
        else if (r < 22) return jmpInst(16'($urandom));
        else if (r < 40) return brInst();
        else             return aluInst();
    endfunction

    function automatic logic [LANES*IW-1:0] randGroup();
        logic [LANES*IW-1:0] g;
        for (int k = 0; k < LANES; k++) g[k*IW +: IW] = randInst();
        return g;
    endfunction

    function automatic bit isJmp(input logic [IW-1:0] inst);
        return inst[31:26] == 6'b110000;
    endfunction

    function automatic bit isBr(input logic [IW-1:0] inst);
        return inst[31:30] == 2'b11 && !isJmp(inst);
    endfunction

    task automatic modelReset();
        m_pc        = '0;
        m_id        = 16'd1;
        m_valid     = '0;
        m_taken     = '0;
        m_target    = '0;
        m_lane_pc   = '0;
        m_lane_id   = '0;
        m_lane_inst = '0;
    endtask

    // Called at a falling edge: drive one cycle of inputs, check the
    // predictor lookup PC, advance the model and queue the expected response
    // for the monitor, then return at the next falling edge.
    task automatic applyStimulus(input logic [FW-1:0] f, input logic st, input logic fl,
                                 input logic [AW-1:0] fa, input logic bt,
                                 input logic [AW-1:0] btgt, input logic [LANES*IW-1:0] insts);
        int            n;
        int            used;
        int            tk;
        logic [AW-1:0] exp_bp;
        logic [AW-1:0] next;
        logic [IW-1:0] inst;
        exp_t          e;
        bus.free       = f;
        bus.stall      = st;
        bus.flush      = fl;
        bus.flush_addr = fa;
        bus.bp_take    = bt;
        bus.bp_target  = btgt;
        bus.imem_inst  = insts;
        #1;
        n = (int'(f) > LANES) ? LANES : int'(f);

        exp_bp = m_pc;
        for (int k = 0; k < n; k++) begin
            inst = insts[k*IW +: IW];
            if (isJmp(inst)) break;
            if (isBr(inst)) begin
                exp_bp = m_pc + AW'(k);
                break;
            end
        end
        checkOutput("bp_pc", bus.bp_pc, exp_bp);

        if (fl) begin
            m_pc    = fa;
            m_valid = '0;
            m_taken = '0;
        end else if (!st && n != 0) begin
            used = n;
            tk   = -1;
            next = m_pc + AW'(n);
            for (int k = 0; k < n; k++) begin
                inst = insts[k*IW +: IW];
                if (isJmp(inst)) begin
                    used = k + 1;
                    next = inst[15:0];
                    break;
                end
                if (isBr(inst)) begin
                    if (bt) begin
                        used = k + 1;
                        tk   = k;
                        next = btgt;
                        break;
                    end
                    bt = 1'b0;
                end
            end
            m_valid     = '0;
            m_taken     = '0;
            m_target    = '0;
            m_lane_id   = '0;
            m_lane_pc   = '0;
            m_lane_inst = '0;
            for (int k = 0; k < used; k++) begin
                inst = insts[k*IW +: IW];
                if (inst != '0) begin
                    m_valid[k]               = 1'b1;
                    m_lane_id[k*IDW +: IDW]  = m_id;
                    m_lane_pc[k*AW +: AW]    = m_pc + AW'(k);
                    m_lane_inst[k*IW +: IW]  = inst;
                    m_id                     = m_id + 16'd1;
                end
            end
            if (tk >= 0) begin
                m_taken[tk] = 1'b1;
                m_target    = btgt;
            end
            m_pc = next;
        end

        e.pc        = m_pc;
        e.valid     = m_valid;
        e.taken     = m_taken;
        e.target    = m_target;
        e.lane_pc   = m_lane_pc;
        e.lane_id   = m_lane_id;
        e.lane_inst = m_lane_inst;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: shortly after every rising edge, compare the registered
    // outputs with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("fetch_pc", bus.fetch_pc, e.pc);
                checkOutput("out_valid", bus.out_valid, e.valid);
                checkOutput("out_taken", bus.out_taken, e.taken);
                checkOutput("out_id", bus.out_id, e.lane_id);
                if (e.taken != '0) checkOutput("out_target", bus.out_target, e.target);
                for (int k = 0; k < LANES; k++) begin
                    if (e.valid[k]) begin
                        checkOutput($sformatf("out_pc[%0d]", k), bus.out_pc[k*AW +: AW], e.lane_pc[k*AW +: AW]);
                        checkOutput($sformatf("out_inst[%0d]", k), bus.out_inst[k*IW +: IW], e.lane_inst[k*IW +: IW]);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #500000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pc"}, bus.fetch_pc, '0);
        checkOutput({tag, "_valid"}, bus.out_valid, '0);
        checkOutput({tag, "_taken"}, bus.out_taken, '0);
        checkOutput({tag, "_target"}, bus.out_target, '0);
        checkOutput({tag, "_out_pc"}, bus.out_pc, '0);
        checkOutput({tag, "_out_id"}, bus.out_id, '0);
        checkOutput({tag, "_out_inst"}, bus.out_inst, '0);
    endtask

    // Main sequence: directed scenarios first, then random traffic with a
    // reset dropped in the middle.
    initial begin
        logic [LANES*IW-1:0] g;
        logic [FW-1:0]       f;
        checks = 0;
        errors = 0;
        reset          = 1'b1;
        bus.free       = '0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_addr = '0;
        bus.bp_take    = 1'b0;
        bus.bp_target  = '0;
        bus.imem_inst  = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;
        $display("[TB] reset released");

        // full-width groups, then a partial group and a hold
        applyStimulus(3'd4, 0, 0, '0, 0, '0, {aluInst(), aluInst(), aluInst(), aluInst()});
        applyStimulus(3'd4, 0, 0, '0, 0, '0, {aluInst(), aluInst(), aluInst(), aluInst()});
        applyStimulus(3'd2, 0, 0, '0, 0, '0, {aluInst(), aluInst(), aluInst(), aluInst()});
        applyStimulus(3'd0, 0, 0, '0, 0, '0, {aluInst(), aluInst(), aluInst(), aluInst()});
        applyStimulus(3'd4, 1, 0, '0, 0, '0, {aluInst(), aluInst(), aluInst(), aluInst()});

        // jump in lane 1
        applyStimulus(3'd4, 0, 1, 16'h0020, 0, '0, '0);
        applyStimulus(3'd4, 0, 0, '0, 0, '0, {aluInst(), aluInst(), jmpInst(16'h0040), aluInst()});

        // taken branch in lane 2, then the same shape not taken
        applyStimulus(3'd4, 0, 0, '0, 1, 16'h0100, {aluInst(), brInst(), aluInst(), aluInst()});
        applyStimulus(3'd4, 0, 0, '0, 0, 16'h0200, {aluInst(), brInst(), aluInst(), aluInst()});

        // NOP in lane 0
        applyStimulus(3'd4, 0, 0, '0, 0, '0, {aluInst(), aluInst(), aluInst(), 32'h0});

        // PC wrap, then flush overriding stall
        applyStimulus(3'd4, 0, 1, 16'hFFFE, 0, '0, '0);
        applyStimulus(3'd4, 0, 0, '0, 0, '0, {aluInst(), aluInst(), aluInst(), aluInst()});
        applyStimulus(3'd4, 1, 1, 16'h0300, 0, '0, {aluInst(), aluInst(), aluInst(), aluInst()});
        applyStimulus(3'd7, 0, 0, '0, 1, 16'h0777, {brInst(), brInst(), aluInst(), aluInst()});

        // random traffic
        for (int c = 0; c < 400; c++) begin
            g = randGroup();
            f = ($urandom_range(0, 99) < 50) ? 3'd4 : FW'($urandom_range(0, 7));
            applyStimulus(f, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
                          AW'($urandom), 1'($urandom), AW'($urandom), g);
        end

        // reset in the middle of traffic
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        $display("[TB] mid-run reset released");
        for (int c = 0; c < 40; c++) begin
            applyStimulus(3'd4, 0, 0, '0, 1'($urandom), AW'($urandom), randGroup());
        end

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        checkOutput("queue_drained", 128'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
